// File: rtl/idu_stage.sv
// ----------------------------------------------------------------------------
// idu_stage -- registered, handshaked instruction-decode pipeline stage.
//
// Takes a 32-bit instruction plus its PC from fetch (valid/ready), splits the
// fields, builds the sign-extended immediate, classifies the instruction type
// and flags illegal encodings. Results go to execute through a two-entry
// buffer (main + skid) so that in_ready never depends combinationally on
// out_ready.
//
// Parameters
//   XLEN    32 or 64 : width of pc / imm, immediates sign-extended to XLEN
//   NR_REG  32 or 16 : register-file size (RVI / RVE)
//
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   in_valid/in_ready              fetch handshake
//   in_inst[31:0], in_pc[XLEN-1:0] instruction word and its address
//   flush                          drop every buffered entry (redirect)
//   out_valid/out_ready            execute handshake
//   out_pc, out_opcode, out_func3, out_func7,
//   out_rs1, out_rs2, out_rd       raw fields / passthrough PC
//   out_imm                        selected immediate (0 for R and illegal)
//   out_itype[5:0]                 one-hot {R,I,S,B,U,J}, 0 when illegal
//   out_illegal                    illegal-instruction flag
// ----------------------------------------------------------------------------
module idu_stage #(
    parameter int XLEN   = 32,
    parameter int NR_REG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [5:0]      out_itype,
    output logic            out_illegal
);

    localparam int EW = 2 * XLEN + 39;

    // itype one-hot encodings, MSB first: {R,I,S,B,U,J}
    localparam logic [5:0] T_R = 6'b100000;
    localparam logic [5:0] T_I = 6'b010000;
    localparam logic [5:0] T_S = 6'b001000;
    localparam logic [5:0] T_B = 6'b000100;
    localparam logic [5:0] T_U = 6'b000010;
    localparam logic [5:0] T_J = 6'b000001;

    // ------------------------------------------------------------------
    // Field split
    // ------------------------------------------------------------------
    logic [6:0] dec_opcode;
    logic [2:0] dec_func3;
    logic [6:0] dec_func7;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic [4:0] dec_rd;

    assign dec_opcode = in_inst[6:0];
    assign dec_func3  = in_inst[14:12];
    assign dec_func7  = in_inst[31:25];
    assign dec_rs1    = in_inst[19:15];
    assign dec_rs2    = in_inst[24:20];
    assign dec_rd     = in_inst[11:7];

    // Register index out of range: only the RVE file (16 regs) can have one.
    logic hi_rs1, hi_rs2, hi_rd;

    generate
        if (NR_REG < 32) begin : g_rve
            assign hi_rs1 = dec_rs1[4];
            assign hi_rs2 = dec_rs2[4];
            assign hi_rd  = dec_rd[4];
        end else begin : g_rvi
            assign hi_rs1 = 1'b0;
            assign hi_rs2 = 1'b0;
            assign hi_rd  = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Type classification and 32-bit immediate
    // ------------------------------------------------------------------
    logic [5:0]  raw_itype;
    logic [31:0] raw_imm32;
    logic        bad_reg;
    logic        dec_illegal;
    logic [5:0]  dec_itype;
    logic [31:0] dec_imm32;

    always_comb begin
        raw_itype = '0;
        raw_imm32 = '0;
        bad_reg   = 1'b0;
        case (dec_opcode)
            7'b0110011: begin
                raw_itype = T_R;
                bad_reg   = hi_rs1 | hi_rs2 | hi_rd;
            end
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                raw_itype = T_I;
                raw_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                bad_reg   = hi_rs1 | hi_rd;
            end
            7'b0100011: begin
                raw_itype = T_S;
                raw_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                bad_reg   = hi_rs1 | hi_rs2;
            end
            7'b1100011: begin
                raw_itype = T_B;
                raw_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                             in_inst[30:25], in_inst[11:8], 1'b0};
                bad_reg   = hi_rs1 | hi_rs2;
            end
            7'b0110111, 7'b0010111: begin
                raw_itype = T_U;
                raw_imm32 = {in_inst[31:12], 12'b0};
                bad_reg   = hi_rd;
            end
            7'b1101111: begin
                raw_itype = T_J;
                raw_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                             in_inst[20], in_inst[30:21], 1'b0};
                bad_reg   = hi_rd;
            end
            default: begin
                raw_itype = '0;
            end
        endcase
    end

    // Unknown opcode shows up as raw_itype == 0.
    assign dec_illegal = (in_inst[1:0] != 2'b11) || (raw_itype == 6'b0) || bad_reg;
    assign dec_itype   = dec_illegal ? 6'b0  : raw_itype;
    assign dec_imm32   = dec_illegal ? 32'b0 : raw_imm32;

    // Sign-extend to XLEN (bit 31 is the sign for every format, U included).
    logic [XLEN-1:0] dec_imm;

    generate
        if (XLEN > 32) begin : g_imm_wide
            assign dec_imm = {{(XLEN-32){dec_imm32[31]}}, dec_imm32};
        end else begin : g_imm_narrow
            assign dec_imm = dec_imm32;
        end
    endgenerate

    logic [EW-1:0] dec_entry;

    assign dec_entry = {in_pc, dec_opcode, dec_func3, dec_func7, dec_rs1,
                        dec_rs2, dec_rd, dec_imm, dec_itype, dec_illegal};

    // ------------------------------------------------------------------
    // Two-entry buffer: main drives the outputs, skid catches the one
    // extra entry accepted in the cycle execute stalls.
    // ------------------------------------------------------------------
    logic [EW-1:0] main_reg;
    logic [EW-1:0] skid_reg;
    logic          main_valid_reg;
    logic          skid_valid_reg;
    logic          accept;
    logic          pop;

    assign in_ready  = !skid_valid_reg;
    assign out_valid = main_valid_reg;
    assign accept    = in_valid && in_ready && !flush;
    assign pop       = main_valid_reg && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (flush) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (pop) begin
            if (skid_valid_reg) begin
                // in_ready is low here, so no accept can collide with this move
                main_reg       <= skid_reg;
                main_valid_reg <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else if (accept) begin
                main_reg       <= dec_entry;
                main_valid_reg <= 1'b1;
            end else begin
                main_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_reg) begin
                main_reg       <= dec_entry;
                main_valid_reg <= 1'b1;
            end else begin
                skid_reg       <= dec_entry;
                skid_valid_reg <= 1'b1;
            end
        end
    end

    assign {out_pc, out_opcode, out_func3, out_func7, out_rs1, out_rs2,
            out_rd, out_imm, out_itype, out_illegal} = main_reg;

endmodule

// File: tb/tb_idu_stage.sv
// ----------------------------------------------------------------------------
// tb_idu_stage -- directed bench for idu_stage.
// Three instances share one stimulus stream: RV32I (default), RV32E
// (NR_REG=16) and RV64I (XLEN=64). Each test checks the instance whose
// configuration it targets.
// ----------------------------------------------------------------------------
module tb_idu_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [63:0] in_pc64;
    logic        flush;
    logic        out_ready;

    // RV32I instance
    logic        a_in_ready, a_out_valid, a_illegal;
    logic [31:0] a_pc, a_imm;
    logic [6:0]  a_opcode, a_func7;
    logic [2:0]  a_func3;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [5:0]  a_itype;

    // RV32E instance
    logic        e_in_ready, e_out_valid, e_illegal;
    logic [31:0] e_pc, e_imm;
    logic [6:0]  e_opcode, e_func7;
    logic [2:0]  e_func3;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [5:0]  e_itype;

    // RV64I instance
    logic        w_in_ready, w_out_valid, w_illegal;
    logic [63:0] w_pc, w_imm;
    logic [6:0]  w_opcode, w_func7;
    logic [2:0]  w_func3;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [5:0]  w_itype;

    int total = 0;
    int bad   = 0;

    idu_stage #(.XLEN(32), .NR_REG(32)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_pc),
        .out_opcode(a_opcode), .out_func3(a_func3), .out_func7(a_func7),
        .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm),
        .out_itype(a_itype), .out_illegal(a_illegal)
    );

    idu_stage #(.XLEN(32), .NR_REG(16)) dut_e (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_pc),
        .out_opcode(e_opcode), .out_func3(e_func3), .out_func7(e_func7),
        .out_rs1(e_rs1), .out_rs2(e_rs2), .out_rd(e_rd), .out_imm(e_imm),
        .out_itype(e_itype), .out_illegal(e_illegal)
    );

    idu_stage #(.XLEN(64), .NR_REG(32)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_inst(in_inst), .in_pc(in_pc64), .flush(flush),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_pc(w_pc),
        .out_opcode(w_opcode), .out_func3(w_func3), .out_func7(w_func7),
        .out_rs1(w_rs1), .out_rs2(w_rs2), .out_rd(w_rd), .out_imm(w_imm),
        .out_itype(w_itype), .out_illegal(w_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        in_pc64  = {32'h0, pc};
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        in_pc64   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // ---- reset state
        #1;
        chk("rst_out_valid", {63'b0, a_out_valid}, 64'd0);
        chk("rst_in_ready",  {63'b0, a_in_ready},  64'd1);
        chk("rst_imm",       {32'b0, a_imm},       64'd0);
        chk("rst_pc",        {32'b0, a_pc},        64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- addi x1,x0,-1
        out_ready = 1'b1;
        offer(32'hFFF00093, 32'h100);
        step();
        chk("addi_valid",   {63'b0, a_out_valid}, 64'd1);
        chk("addi_itype",   {58'b0, a_itype},     64'h10);
        chk("addi_rd",      {59'b0, a_rd},        64'd1);
        chk("addi_rs1",     {59'b0, a_rs1},       64'd0);
        chk("addi_imm",     {32'b0, a_imm},       64'hFFFFFFFF);
        chk("addi_illegal", {63'b0, a_illegal},   64'd0);
        chk("addi_pc",      {32'b0, a_pc},        64'h100);

        // ---- beq then jal back-to-back
        offer(32'hFE000EE3, 32'h104);
        step();
        chk("beq_imm",   {32'b0, a_imm},   64'hFFFFFFFC);
        chk("beq_itype", {58'b0, a_itype}, 64'h04);
        offer(32'h0080006F, 32'h108);
        step();
        chk("jal_valid", {63'b0, a_out_valid}, 64'd1);
        chk("jal_imm",   {32'b0, a_imm},   64'h8);
        chk("jal_itype", {58'b0, a_itype}, 64'h01);
        in_valid = 1'b0;
        step();
        chk("drain_valid", {63'b0, a_out_valid}, 64'd0);

        // ---- backpressure: A, B accepted, C held, then FIFO drain
        out_ready = 1'b0;
        offer(32'h00100113, 32'h200);   // A: addi x2,x0,1
        step();
        chk("bp_a_imm",   {32'b0, a_imm},      64'd1);
        chk("bp_a_ready", {63'b0, a_in_ready}, 64'd1);
        offer(32'h00200193, 32'h204);   // B: addi x3,x0,2
        step();
        chk("bp_b_ready", {63'b0, a_in_ready}, 64'd0);
        offer(32'h00300213, 32'h208);   // C: addi x4,x0,3
        step();
        chk("bp_c_ready", {63'b0, a_in_ready}, 64'd0);
        chk("bp_hold_imm", {32'b0, a_imm},     64'd1);
        out_ready = 1'b1;
        step();
        chk("bp_out_b_imm", {32'b0, a_imm},     64'd2);
        chk("bp_out_b_rd",  {59'b0, a_rd},      64'd3);
        chk("bp_ready_up",  {63'b0, a_in_ready}, 64'd1);
        step();
        chk("bp_out_c_imm", {32'b0, a_imm},       64'd3);
        chk("bp_out_c_vld", {63'b0, a_out_valid}, 64'd1);
        in_valid = 1'b0;
        step();
        chk("bp_empty", {63'b0, a_out_valid}, 64'd0);

        // ---- register range: add x16,x0,x0 and all-zero word
        offer(32'h00000833, 32'h300);
        step();
        chk("rve_valid",   {63'b0, e_out_valid}, 64'd1);
        chk("rve_illegal", {63'b0, e_illegal},   64'd1);
        chk("rve_itype",   {58'b0, e_itype},     64'h00);
        chk("rve_imm",     {32'b0, e_imm},       64'd0);
        chk("rvi_illegal", {63'b0, a_illegal},   64'd0);
        chk("rvi_itype",   {58'b0, a_itype},     64'h20);
        chk("rvi_rd",      {59'b0, a_rd},        64'd16);
        offer(32'h00000000, 32'h304);
        step();
        chk("zero_illegal", {63'b0, a_illegal}, 64'd1);
        chk("zero_itype",   {58'b0, a_itype},   64'h00);
        in_valid = 1'b0;
        step();

        // ---- RV64 lui x1,0x80000
        offer(32'h800000B7, 32'h0);
        in_pc64 = 64'h0000_0001_2345_6780;
        step();
        chk("lui64_imm",   w_imm,            64'hFFFFFFFF80000000);
        chk("lui64_itype", {58'b0, w_itype}, 64'h02);
        chk("lui64_pc",    w_pc,             64'h0000_0001_2345_6780);
        chk("lui32_imm",   {32'b0, a_imm},   64'h80000000);
        in_valid = 1'b0;
        step();

        // ---- flush with two entries buffered and an instruction offered
        out_ready = 1'b0;
        offer(32'h00100113, 32'h400);
        step();
        offer(32'h00200193, 32'h404);
        step();
        chk("fl_full_ready", {63'b0, a_in_ready}, 64'd0);
        flush = 1'b1;
        offer(32'h00300213, 32'h408);
        step();
        chk("fl_valid", {63'b0, a_out_valid}, 64'd0);
        chk("fl_ready", {63'b0, a_in_ready},  64'd1);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("fl_after_valid", {63'b0, a_out_valid}, 64'd0);

        // ---- flush beats an accept that would otherwise land (in_ready=1)
        offer(32'h00100113, 32'h500);
        step();
        flush = 1'b1;
        offer(32'h00300213, 32'h504);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl1_valid", {63'b0, a_out_valid}, 64'd0);
        step();
        chk("fl1_dropped", {63'b0, a_out_valid}, 64'd0);

        // ---- asynchronous reset mid-cycle
        offer(32'h00100113, 32'h600);
        step();
        in_valid = 1'b0;
        chk("ar_pre_valid", {63'b0, a_out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", {63'b0, a_out_valid}, 64'd0);
        chk("ar_ready", {63'b0, a_in_ready},  64'd1);
        chk("ar_imm",   {32'b0, a_imm},       64'd0);
        step();
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
